// File: rtl/simon_pkg.sv
// simon_pkg: shared types and helpers for the Simon Says round sequencer.
//   state_t         - sequencer FSM states
//   color_t         - 3-bit colour code (0-3 valid, 4-7 invalid)
//   RED..YELLOW     - valid colour codes
//   color_to_onehot - colour code to 4-bit button pattern, 0 for invalid codes
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SHOW         = 3'd1,
    GAP          = 3'd2,
    WAIT_PRESS   = 3'd3,
    WAIT_RELEASE = 3'd4,
    ROUND_DONE   = 3'd5,
    LOSE         = 3'd6,
    WIN          = 3'd7
  } state_t;

  typedef logic [2:0] color_t;

  localparam color_t RED    = 3'd0;
  localparam color_t GREEN  = 3'd1;
  localparam color_t BLUE   = 3'd2;
  localparam color_t YELLOW = 3'd3;

  // An invalid code maps to 0, which never equals a non-zero press.
  function automatic logic [3:0] color_to_onehot(input color_t c);
    if (c[2]) return 4'b0000;
    return 4'(4'b0001 << c[1:0]);
  endfunction

endpackage

// File: rtl/simon_timer.sv
// simon_timer: loadable down-counter with a terminal flag.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - load load_val this cycle (wins over counting)
//   load_val   - value to load; done rises load_val cycles after the load
//   done       - high while the count is zero
module simon_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/simon_round_ctrl.sv
// simon_round_ctrl: Simon Says round sequencer.
// Plays segment entries 0..round as colour flashes, then checks each player
// press against the expected entry, advancing rounds until a loss or a win.
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - one-cycle pulse, starts a game from IDLE/LOSE/WIN
//   segment      - colour sequence, entry i in segment[i]
//   player_input - raw button levels, one bit per colour
//   show_en      - colour display active; show_color valid while high
//   show_color   - colour code being displayed
//   check_round  - current round index (0-based)
//   step_idx     - sequence position being shown or expected
//   round_pass   - one-cycle pulse on a correctly completed round
//   game_over    - level, player lost
//   win          - level, all MAX_LEN rounds completed
//   busy         - high in every state except IDLE, LOSE and WIN
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int MAX_LEN        = 32,
  parameter int SHOW_CYCLES    = 25000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [MAX_LEN-1:0][2:0]      segment,
  input  logic [3:0]                   player_input,
  output logic                         show_en,
  output logic [2:0]                   show_color,
  output logic [$clog2(MAX_LEN)-1:0]   check_round,
  output logic [$clog2(MAX_LEN)-1:0]   step_idx,
  output logic                         round_pass,
  output logic                         game_over,
  output logic                         win,
  output logic                         busy
);

  localparam int IDX_W   = $clog2(MAX_LEN);
  localparam int TMR_MAX = (SHOW_CYCLES > GAP_CYCLES)
                           ? ((SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES)
                           : ((GAP_CYCLES  > TIMEOUT_CYCLES) ? GAP_CYCLES  : TIMEOUT_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] step_q, step_d;
  logic [IDX_W-1:0] round_q, round_d;
  logic [3:0]       pin_q;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_done;

  color_t           cur_color;
  logic             press;
  logic             press_ok;

  assign cur_color = segment[step_q];

  // A press is a 0 -> non-zero edge, so buttons already held when waiting
  // begins are not taken as a press until they are released first.
  assign press    = (state_q == WAIT_PRESS) && (pin_q == 4'b0000) && (player_input != 4'b0000);
  assign press_ok = $onehot(player_input) && (player_input == color_to_onehot(cur_color));

  // One shared timer, reloaded on every state entry with the dwell for the
  // state being entered; a count of N-1 makes done rise after N cycles.
  assign tmr_load = (state_d != state_q);

  always_comb begin
    tmr_load_val = '0;
    unique case (state_d)
      SHOW:       tmr_load_val = TMR_W'(SHOW_CYCLES - 1);
      GAP:        tmr_load_val = TMR_W'(GAP_CYCLES - 1);
      WAIT_PRESS: tmr_load_val = TMR_W'(TIMEOUT_CYCLES - 1);
      default:    tmr_load_val = '0;
    endcase
  end

  simon_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .done     (tmr_done)
  );

  // State register together with the round/step indices and the button sampler.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      round_q <= '0;
      pin_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      round_q <= round_d;
      pin_q   <= player_input;
    end
  end

  // Next-state logic.
  // NOTE: every comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    round_d = round_q;
    unique case (state_q)
      IDLE, LOSE, WIN: begin
        if (start) begin
          state_d = SHOW;
          step_d  = '0;
          round_d = '0;
        end
      end
      SHOW: begin
        if (tmr_done) state_d = GAP;
      end
      GAP: begin
        if (tmr_done) begin
          if (step_q == round_q) begin
            step_d  = '0;
            state_d = WAIT_PRESS;
          end else begin
            step_d  = step_q + 1'b1;
            state_d = SHOW;
          end
        end
      end
      WAIT_PRESS: begin
        // A press in the final timeout cycle still counts.
        if (press) begin
          state_d = press_ok ? WAIT_RELEASE : LOSE;
        end else if (tmr_done) begin
          state_d = LOSE;
        end
      end
      WAIT_RELEASE: begin
        if (player_input == 4'b0000) begin
          if (step_q == round_q) begin
            state_d = ROUND_DONE;
          end else begin
            step_d  = step_q + 1'b1;
            state_d = WAIT_PRESS;
          end
        end
      end
      ROUND_DONE: begin
        // The WIN check comes before the increment, so round_q never wraps.
        if (round_q == IDX_W'(MAX_LEN - 1)) begin
          state_d = WIN;
        end else begin
          round_d = round_q + 1'b1;
          step_d  = '0;
          state_d = SHOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the current state only, so reset clears them at once.
  always_comb begin
    show_en    = (state_q == SHOW);
    show_color = show_en ? cur_color : 3'd0;
    round_pass = (state_q == ROUND_DONE);
    game_over  = (state_q == LOSE);
    win        = (state_q == WIN);
    busy       = !((state_q == IDLE) || (state_q == LOSE) || (state_q == WIN));
  end

  assign check_round = round_q;
  assign step_idx    = step_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// tb_simon_round_ctrl: directed bench for simon_round_ctrl with a short
// configuration (4 rounds, 3-cycle flashes, 2-cycle gaps, 20-cycle timeout).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_simon_round_ctrl;

  localparam int MAX_LEN = 4;
  localparam int IDX_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic [MAX_LEN-1:0][2:0] segment;
  logic [3:0]              player_input;
  logic                    show_en;
  logic [2:0]              show_color;
  logic [IDX_W-1:0]        check_round;
  logic [IDX_W-1:0]        step_idx;
  logic                    round_pass;
  logic                    game_over;
  logic                    win;
  logic                    busy;

  int n_checks = 0;
  int n_errors = 0;

  simon_round_ctrl #(
    .MAX_LEN        (MAX_LEN),
    .SHOW_CYCLES    (3),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .segment      (segment),
    .player_input (player_input),
    .show_en      (show_en),
    .show_color   (show_color),
    .check_round  (check_round),
    .step_idx     (step_idx),
    .round_pass   (round_pass),
    .game_over    (game_over),
    .win          (win),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".show_en"},     32'(show_en),     32'd0);
    check({tag, ".show_color"},  32'(show_color),  32'd0);
    check({tag, ".check_round"}, 32'(check_round), 32'd0);
    check({tag, ".step_idx"},    32'(step_idx),    32'd0);
    check({tag, ".round_pass"},  32'(round_pass),  32'd0);
    check({tag, ".game_over"},   32'(game_over),   32'd0);
    check({tag, ".win"},         32'(win),         32'd0);
    check({tag, ".busy"},        32'(busy),        32'd0);
  endtask

  // Pulse start; returns positioned at the first SHOW cycle.
  task automatic do_start();
    player_input = 4'b0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start.game_over",   32'(game_over),   32'd0);
    check("start.win",         32'(win),         32'd0);
    check("start.check_round", 32'(check_round), 32'd0);
  endtask

  // Checks the playback of round r; returns at the first WAIT_PRESS cycle.
  task automatic play_round(input int r);
    for (int i = 0; i <= r; i++) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("r%0d.show%0d.en", r, i),    32'(show_en),    32'd1);
        check($sformatf("r%0d.show%0d.color", r, i), 32'(show_color), 32'(segment[i]));
        check($sformatf("r%0d.show%0d.step", r, i),  32'(step_idx),   32'(i));
        @(negedge clk);
      end
      for (int k = 0; k < 2; k++) begin
        check($sformatf("r%0d.gap%0d.en", r, i), 32'(show_en), 32'd0);
        check($sformatf("r%0d.gap%0d.busy", r, i), 32'(busy), 32'd1);
        @(negedge clk);
      end
    end
    check($sformatf("r%0d.wait.round", r), 32'(check_round), 32'(r));
    check($sformatf("r%0d.wait.step", r),  32'(step_idx),    32'd0);
  endtask

  // Press then release; returns in WAIT_PRESS or ROUND_DONE.
  task automatic press_release(input logic [3:0] val);
    player_input = val;
    @(negedge clk);
    check("press.no_lose", 32'(game_over), 32'd0);
    player_input = 4'b0000;
    @(negedge clk);
  endtask

  task automatic press_expect_lose(input string tag, input logic [3:0] val);
    player_input = val;
    @(negedge clk);
    check({tag, ".game_over"}, 32'(game_over), 32'd1);
    check({tag, ".busy"},      32'(busy),      32'd0);
    player_input = 4'b0000;
  endtask

  logic [3:0] exp_btn;

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    player_input = 4'b0000;
    segment      = {3'd3, 3'd2, 3'd1, 3'd0};
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.busy", 32'(busy), 32'd0);

    // Round 0 correct, then wrong press at step 1 of round 1.
    do_start();
    play_round(0);
    press_release(4'b0001);
    check("r0.round_pass", 32'(round_pass), 32'd1);
    check("r0.done_round", 32'(check_round), 32'd0);
    @(negedge clk);
    check("r1.round_pass_low", 32'(round_pass), 32'd0);
    check("r1.check_round", 32'(check_round), 32'd1);
    play_round(1);
    press_release(4'b0001);
    check("r1.step1", 32'(step_idx), 32'd1);
    press_expect_lose("wrong_color", 4'b0100);
    @(negedge clk);
    check("lose.held", 32'(game_over), 32'd1);

    // Timeout: exactly 20 idle WAIT_PRESS cycles, then LOSE.
    do_start();
    play_round(0);
    repeat (19) @(negedge clk);
    check("timeout.last_wait", 32'(game_over), 32'd0);
    check("timeout.last_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("timeout.game_over", 32'(game_over), 32'd1);
    check("timeout.busy", 32'(busy), 32'd0);
    do_start();
    check("restart.show_en", 32'(show_en), 32'd1);

    // Multi-button press at step 0.
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    press_expect_lose("multi_press", 4'b0011);

    // Full game to WIN.
    do_start();
    for (int r = 0; r < MAX_LEN; r++) begin
      play_round(r);
      for (int i = 0; i <= r; i++) begin
        exp_btn = 4'(4'b0001 << segment[i][1:0]);
        press_release(exp_btn);
      end
      check($sformatf("win_r%0d.round_pass", r), 32'(round_pass), 32'd1);
      check($sformatf("win_r%0d.check_round", r), 32'(check_round), 32'(r));
      @(negedge clk);
      check($sformatf("win_r%0d.pass_low", r), 32'(round_pass), 32'd0);
      if (r < MAX_LEN - 1)
        check($sformatf("win_r%0d.next_round", r), 32'(check_round), 32'(r + 1));
    end
    check("win.win", 32'(win), 32'd1);
    check("win.busy", 32'(busy), 32'd0);
    check("win.check_round", 32'(check_round), 32'd3);
    player_input = 4'b0001;
    @(negedge clk);
    player_input = 4'b0000;
    @(negedge clk);
    check("win.held", 32'(win), 32'd1);
    check("win.no_wrap", 32'(check_round), 32'd3);
    check("win.no_game_over", 32'(game_over), 32'd0);

    // Invalid colour code 5 at entry 0; its low bits would match 4'b0010.
    segment[0] = 3'd5;
    do_start();
    play_round(0);
    press_expect_lose("invalid_code", 4'b0010);
    segment[0] = 3'd0;

    // Asynchronous reset in the middle of SHOW.
    do_start();
    check("mid.show_en", 32'(show_en), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset.busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/simon_round_ctrl.md
Name: simon_round_ctrl

Overview:
- Game sequencer for the Simon Says verification datapath.
- Each round: plays back segment entries 0..round as colour flashes, then collects player button presses and checks each press against the expected segment entry.
- Drives check_round, which the verify_input path consumes, and signals pass, lose and win to the top-level game FSM.

Parameters:
- MAX_LEN, 32, number of sequence entries and maximum rounds.
- SHOW_CYCLES, 25000000, clock cycles each colour is displayed.
- GAP_CYCLES, 12500000, dark cycles between flashes.
- TIMEOUT_CYCLES, 250000000, idle cycles allowed while waiting for a press before a loss.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse that begins a new game.
- segment, input, [MAX_LEN-1:0][2:0], colour sequence; codes 0-3 are valid, 4-7 are invalid.
- player_input, input, 4, raw button levels, one bit per colour.
- show_en, output, 1, colour display active.
- show_color, output, 3, colour code being displayed; valid when show_en=1.
- check_round, output, 5, current round index (0-based).
- step_idx, output, 5, sequence position being shown or expected.
- round_pass, output, 1, one-cycle pulse when a round completes correctly.
- game_over, output, 1, level; player lost.
- win, output, 1, level; all MAX_LEN rounds completed.
- busy, output, 1, high in every state except IDLE, LOSE and WIN.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: check_round, step_idx, show_color, show_en, round_pass, game_over, win, busy.
  - Timers and the input register cleared.
- States: IDLE, SHOW, GAP, WAIT_PRESS, WAIT_RELEASE, ROUND_DONE, LOSE, WIN.
- IDLE/LOSE/WIN + start:
  - check_round=0, step_idx=0, game_over=0, win=0.
  - Next state SHOW.
  - start is ignored in every other state.
- SHOW:
  - show_en=1, show_color=segment[step_idx].
  - After SHOW_CYCLES cycles, go to GAP.
- GAP:
  - show_en=0.
  - After GAP_CYCLES cycles: if step_idx==check_round, set step_idx=0 and go to WAIT_PRESS; otherwise increment step_idx and go to SHOW.
- Press detection:
  - player_input is registered once as pin_q.
  - press = (pin_q==0) && (player_input!=0), evaluated in WAIT_PRESS only.
  - The comparison is made in the press cycle; the state update is registered, so the decision is visible one cycle after the press.
- WAIT_PRESS:
  - Timeout counter increments every cycle and clears on entry.
  - Counter reaching TIMEOUT_CYCLES-1 -> LOSE.
  - On press, correct means both: player_input is exactly one-hot, and player_input == (4'b1 << segment[step_idx][1:0]) with segment[step_idx][2]==0.
  - Correct press -> WAIT_RELEASE. Wrong press -> LOSE.
  - A multi-button press or an invalid code (4-7) is always wrong.
- WAIT_RELEASE:
  - Wait for player_input==0. No timeout applies here.
  - Then, if step_idx==check_round, go to ROUND_DONE; otherwise increment step_idx and go to WAIT_PRESS.
- ROUND_DONE:
  - round_pass=1 for exactly one cycle.
  - If check_round==MAX_LEN-1, go to WIN; otherwise increment check_round, set step_idx=0 and go to SHOW.
- LOSE: game_over=1, held until start or reset.
- WIN: win=1, held until start or reset.
- Widths:
  - check_round and step_idx are $clog2(MAX_LEN) bits; 5 bits at the default.
  - They never wrap, because the WIN check precedes the increment.
- Timers are a single shared down-counter, reloaded on every state entry.
- Buttons held at start: no press is detected until a 0->nonzero edge occurs, because pin_q must first be 0.
- Reset mid-game returns to IDLE immediately and discards all progress.

Decomposition:
- Package simon_pkg holds:
  - state_t enum.
  - color_t as a 3-bit logic type.
  - Colour constants RED, GREEN, BLUE, YELLOW = 0..3.
  - Function color_to_onehot returning a 4-bit value, 0 for invalid codes.
- One sub-module, simon_timer: loadable down-counter with a done flag, shared by SHOW, GAP and timeout.
- The FSM stays in simon_round_ctrl.

Test Plan (MAX_LEN=4, SHOW_CYCLES=3, GAP_CYCLES=2, TIMEOUT_CYCLES=20, segment={3,2,1,0}):
- start pulse:
  - show_en=1 with show_color=0 for 3 cycles, then show_en=0 for 2 cycles.
  - Then WAIT_PRESS with check_round=0.
- Round 0 press 4'b0001, then release:
  - round_pass pulses once, check_round=1.
  - Playback shows colours 0 then 1.
- Round 1 presses 4'b0001, then 4'b0100 (expected 4'b0010): game_over=1 one cycle after the press, busy=0.
- No press for 20 cycles in WAIT_PRESS: game_over=1. A following start clears it and sets check_round=0.
- All 4 rounds correct:
  - win=1 after the last release plus ROUND_DONE.
  - check_round stays 3 and does not wrap.
  - Further presses are ignored.
- Extra scenarios:
  - Press 4'b0011 at step 0: game_over=1.
  - segment[0]=3'd5: any press gives game_over=1.
  - Assert rst_n=0 mid-SHOW: all outputs 0 asynchronously.
